// File: rtl/cpu_defs.sv
// Shared CPU definitions: reset vector, fetch FSM states, sram-like bus
// constants and the next-PC selection rule.
package cpu_defs;

  localparam logic [31:0] RESET_PC       = 32'hBFC0_0000;
  localparam logic [1:0]  INST_SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_e;

  // Exception flush beats a latched redirect, which beats a same-cycle branch.
  function automatic logic [31:0] next_pc(
    input logic        refresh,
    input logic [31:0] exc_pc,
    input logic        redirect_pending,
    input logic [31:0] redirect_target,
    input logic        br_taken,
    input logic [31:0] br_target,
    input logic [31:0] pc
  );
    if (refresh) begin
      return exc_pc;
    end else if (redirect_pending) begin
      return redirect_target;
    end else if (br_taken) begin
      return br_target;
    end else begin
      return pc + 32'd4;
    end
  endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// IF-stage fetch initiator: owns the PC, drives the sram-like instruction
// port, buffers one returned word and drops responses made stale by a flush.
module if_fetch_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        refresh,
  input  logic [31:0] exc_pc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_addr_error,
  output logic        if_inst_req,
  output logic        fetch_stall
);

  fetch_state_e state, state_nxt;

  logic [31:0] pc;
  logic [31:0] req_addr;
  logic [31:0] inst_buf;
  logic [31:0] redirect_target;
  logic        buf_valid;
  logic        redirect_pending;
  logic        kill;
  logic        pc_misaligned;
  logic        err_slot;
  logic        consume;

  assign pc_misaligned = (pc[1:0] != 2'b00);
  assign err_slot      = (state == IDLE) && pc_misaligned;
  assign if_valid      = buf_valid || err_slot;
  assign consume       = if_valid && !stall;

  // Bus side is a pure decode of registered state; the address is captured
  // at request start so a flush moving pc cannot disturb a pending request.
  assign inst_req  = (state == REQ);
  assign inst_wr   = 1'b0;
  assign inst_size = INST_SIZE_WORD;
  assign inst_addr = req_addr;

  assign if_pc         = pc;
  assign if_inst       = buf_valid ? inst_buf : 32'h0000_0000;
  assign if_addr_error = err_slot;
  assign if_inst_req   = buf_valid;
  assign fetch_stall   = !if_valid;

  // Fetch FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Fetch FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!refresh && !pc_misaligned && !buf_valid) begin
          state_nxt = REQ;
        end else begin
          state_nxt = IDLE;
        end
      end
      REQ: begin
        if (inst_addr_ok) begin
          state_nxt = (kill || refresh) ? DISCARD : WAIT;
        end else begin
          state_nxt = REQ;
        end
      end
      WAIT: begin
        // A flush coinciding with data_ok just drops the word.
        if (inst_data_ok) begin
          state_nxt = IDLE;
        end else if (refresh) begin
          state_nxt = DISCARD;
        end else begin
          state_nxt = WAIT;
        end
      end
      DISCARD: begin
        if (inst_data_ok) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DISCARD;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // PC, instruction buffer, branch redirect and kill-flag registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc               <= RESET_PC;
      req_addr         <= RESET_PC;
      inst_buf         <= 32'h0000_0000;
      buf_valid        <= 1'b0;
      redirect_pending <= 1'b0;
      redirect_target  <= 32'h0000_0000;
      kill             <= 1'b0;
    end else begin
      if (refresh || consume) begin
        pc <= next_pc(refresh, exc_pc, redirect_pending, redirect_target,
                      br_taken, br_target, pc);
      end

      if (state == IDLE && state_nxt == REQ) begin
        req_addr <= pc;
      end

      if (refresh) begin
        buf_valid <= 1'b0;
      end else if (state == WAIT && inst_data_ok) begin
        buf_valid <= 1'b1;
        inst_buf  <= inst_rdata;
      end else if (consume) begin
        buf_valid <= 1'b0;
      end

      // The branch's delay slot is still in IF; hold the target until it leaves.
      if (refresh || consume) begin
        redirect_pending <= 1'b0;
      end else if (br_taken) begin
        redirect_pending <= 1'b1;
        redirect_target  <= br_target;
      end

      if (state == REQ) begin
        kill <= (kill || refresh) && !inst_addr_ok;
      end else begin
        kill <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus a randomized
// run against a program-order PC model and a one-deep sram-like slave.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] EXC_PC   = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        resetn, stall, refresh, br_taken;
  logic [31:0] exc_pc, br_target;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = 32'h0;
  logic        if_valid, if_addr_error, if_inst_req, fetch_stall;
  logic [31:0] if_pc, if_inst;

  int checks = 0;
  int errors = 0;

  if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .resetn(resetn), .stall(stall), .refresh(refresh),
    .exc_pc(exc_pc), .br_taken(br_taken), .br_target(br_target),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_addr_error(if_addr_error), .if_inst_req(if_inst_req),
    .fetch_stall(fetch_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Slave: accepted addresses queue up, each answered after data_delay cycles.
  logic [31:0] sq[$];
  bit rnd = 1'b0;
  int addr_delay = 0, data_delay = 0, req_age = 0, data_age = 0;

  always @(negedge clk) begin
    if (rnd) inst_addr_ok <= ($urandom_range(0, 1) == 1);
    else     inst_addr_ok <= inst_req && (req_age >= addr_delay);
    if (sq.size() > 0) begin
      inst_data_ok <= rnd ? ($urandom_range(0, 2) != 0) : (data_age >= data_delay);
      inst_rdata   <= mem_word(sq[0]);
    end else begin
      inst_data_ok <= 1'b0;
      inst_rdata   <= $urandom;
    end
  end

  always @(posedge clk) begin
    if (!resetn) begin
      sq.delete();
      req_age  <= 0;
      data_age <= 0;
    end else begin
      if (inst_data_ok && sq.size() > 0) begin
        void'(sq.pop_front());
        data_age <= 0;
      end else if (sq.size() > 0) begin
        data_age <= data_age + 1;
      end
      if (inst_req && inst_addr_ok) sq.push_back(inst_addr);
      req_age <= (inst_req && !inst_addr_ok) ? req_age + 1 : 0;
    end
  end

  // Reference: which PC the next delivered instruction must carry.
  logic [31:0] exp_pc, pend_tgt;
  bit pend;
  int delivered;

  always @(posedge clk) begin
    if (!resetn) begin
      exp_pc    <= RESET_PC;
      pend      <= 1'b0;
      delivered <= 0;
    end else if (refresh) begin
      exp_pc <= exc_pc;
      pend   <= 1'b0;
    end else if (if_valid && !stall) begin
      exp_pc    <= pend ? pend_tgt : (br_taken ? br_target : exp_pc + 32'd4);
      pend      <= 1'b0;
      delivered <= delivered + 1;
    end else if (br_taken) begin
      pend     <= 1'b1;
      pend_tgt <= br_target;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; stall = 1'b0; refresh = 1'b0; br_taken = 1'b0;
    exc_pc = 32'h0; br_target = 32'h0;
    repeat (2) tick();
    resetn = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (if_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_req(input int budget, output bit ok, output int nvalid);
    ok = 1'b0; nvalid = 0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (if_valid) nvalid++;
      if (inst_req) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [31:0] got[9], want[9];
    resetn = 1'b0; stall = 1'b0; refresh = 1'b0; br_taken = 1'b0;
    exc_pc = 32'h0; br_target = 32'h0;
    repeat (2) tick();
    got  = '{32'(inst_req), 32'(if_valid), if_inst, 32'(if_addr_error), 32'(if_inst_req),
             32'(fetch_stall), 32'(inst_wr), 32'(inst_size), if_pc};
    want = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd2, RESET_PC};
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got[i] !== want[i]) begin
        errors++;
        $display("FAIL reset[%0d]: got %h want %h", i, got[i], want[i]);
      end
    end
  endtask

  task automatic test_sequential();
    logic [31:0] addrs[$];
    logic [31:0] e;
    int nv = 0;
    rnd = 1'b0; addr_delay = 0; data_delay = 0;
    do_reset();
    for (int c = 0; c < 60 && nv < 3; c++) begin
      tick();
      if (inst_req && inst_addr_ok) addrs.push_back(inst_addr);
      if (if_valid) begin
        e = RESET_PC + 32'(4 * nv);
        checks++;
        if (if_pc !== e || if_inst !== mem_word(e) || if_inst_req !== 1'b1) begin
          errors++;
          $display("FAIL seq_valid[%0d]: pc=%h inst=%h req=%b want pc=%h inst=%h req=1",
                   nv, if_pc, if_inst, if_inst_req, e, mem_word(e));
        end
        nv++;
      end
    end
    checks++;
    if (nv !== 3) begin errors++; $display("FAIL seq_count: got %0d want 3", nv); end
    for (int i = 0; i < 3; i++) begin
      e = RESET_PC + 32'(4 * i);
      checks++;
      if (i >= addrs.size() || addrs[i] !== e) begin
        errors++;
        $display("FAIL seq_addr[%0d]: got %h want %h", i,
                 (i < addrs.size()) ? addrs[i] : 32'hFFFF_FFFF, e);
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    int nv;
    rnd = 1'b0; addr_delay = 0; data_delay = 0;
    do_reset();
    wait_valid(30, ok);
    stall = 1'b1;
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_first: no if_valid within budget"); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== RESET_PC || if_inst !== mem_word(RESET_PC) || inst_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%b pc=%h inst=%h req=%b want 1 %h %h 0",
                 i, if_valid, if_pc, if_inst, inst_req, RESET_PC, mem_word(RESET_PC));
      end
    end
    stall = 1'b0;
    wait_req(30, ok, nv);
    checks++;
    if (!ok || inst_addr !== RESET_PC + 32'd4) begin
      errors++;
      $display("FAIL stall_next: req=%b addr=%h want 1 %h", ok, inst_addr, RESET_PC + 32'd4);
    end
  endtask

  task automatic test_branch();
    bit ok;
    int nv;
    rnd = 1'b0; addr_delay = 0; data_delay = 2;
    do_reset();
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (inst_req && inst_addr_ok && inst_addr == RESET_PC + 32'd4) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL br_slot_req: delay-slot request not seen"); end
    tick();
    br_taken = 1'b1; br_target = 32'h8000_1000;
    tick();
    br_taken = 1'b0;
    if (!if_valid) wait_valid(30, ok);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== RESET_PC + 32'd4 || if_inst !== mem_word(RESET_PC + 32'd4)) begin
      errors++;
      $display("FAIL br_slot: valid=%b pc=%h inst=%h want 1 %h", if_valid, if_pc, if_inst, RESET_PC + 32'd4);
    end
    wait_req(30, ok, nv);
    checks++;
    if (!ok || inst_addr !== 32'h8000_1000) begin
      errors++;
      $display("FAIL br_target_req: req=%b addr=%h want 1 80001000", ok, inst_addr);
    end
    wait_valid(30, ok);
    checks++;
    if (!ok || if_pc !== 32'h8000_1000 || if_inst !== mem_word(32'h8000_1000)) begin
      errors++;
      $display("FAIL br_target_valid: valid=%b pc=%h inst=%h want 80001000", ok, if_pc, if_inst);
    end
  endtask

  task automatic test_refresh_wait();
    bit ok;
    int nv;
    rnd = 1'b0; addr_delay = 0; data_delay = 3;
    do_reset();
    wait_req(30, ok, nv);
    tick();
    refresh = 1'b1; exc_pc = EXC_PC;
    tick();
    refresh = 1'b0;
    wait_req(40, ok, nv);
    checks++;
    if (!ok || nv !== 0 || inst_addr !== EXC_PC) begin
      errors++;
      $display("FAIL refw_req: req=%b stale_valids=%0d addr=%h want 1 0 %h", ok, nv, inst_addr, EXC_PC);
    end
    wait_valid(30, ok);
    checks++;
    if (!ok || if_pc !== EXC_PC || if_inst !== mem_word(EXC_PC)) begin
      errors++;
      $display("FAIL refw_valid: valid=%b pc=%h inst=%h want %h %h", ok, if_pc, if_inst, EXC_PC, mem_word(EXC_PC));
    end
  endtask

  task automatic test_refresh_req();
    bit ok, held;
    int nv;
    rnd = 1'b0; addr_delay = 2; data_delay = 0;
    do_reset();
    wait_req(30, ok, nv);
    refresh = 1'b1; exc_pc = EXC_PC;
    held = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (inst_req !== 1'b1 || inst_addr !== RESET_PC) held = 1'b0;
      if (inst_addr_ok) break;
      tick();
      refresh = 1'b0;
    end
    refresh = 1'b0;
    checks++;
    if (!held || inst_addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL refr_hold: held=%b addr_ok=%b addr=%h want 1 1 %h", held, inst_addr_ok, inst_addr, RESET_PC);
    end
    wait_req(40, ok, nv);
    checks++;
    if (!ok || nv !== 0 || inst_addr !== EXC_PC) begin
      errors++;
      $display("FAIL refr_req: req=%b stale_valids=%0d addr=%h want 1 0 %h", ok, nv, inst_addr, EXC_PC);
    end
  endtask

  task automatic test_addr_error();
    bit ok;
    rnd = 1'b0; addr_delay = 0; data_delay = 1;
    do_reset();
    br_taken = 1'b1; br_target = 32'h8000_1002;
    tick();
    br_taken = 1'b0;
    wait_valid(30, ok);
    checks++;
    if (!ok || if_pc !== RESET_PC) begin
      errors++;
      $display("FAIL aerr_slot: valid=%b pc=%h want 1 %h", ok, if_pc, RESET_PC);
    end
    wait_valid(10, ok);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (if_valid !== 1'b1 || if_addr_error !== 1'b1 || if_inst_req !== 1'b0 ||
          if_inst !== 32'h0 || if_pc !== 32'h8000_1002 || inst_req !== 1'b0) begin
        errors++;
        $display("FAIL aerr[%0d]: valid=%b err=%b ireq=%b inst=%h pc=%h req=%b want 1 1 0 0 80001002 0",
                 i, if_valid, if_addr_error, if_inst_req, if_inst, if_pc, inst_req);
      end
      tick();
    end
    stall = 1'b0;
  endtask

  task automatic test_random();
    bit hold = 1'b0;
    logic [31:0] hold_addr = 32'h0;
    logic [31:0] e;
    rnd = 1'b1;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      tick();
      checks++;
      if (fetch_stall !== !if_valid) begin
        errors++;
        $display("FAIL rnd_fstall@%0d: fetch_stall=%b if_valid=%b", c, fetch_stall, if_valid);
      end
      if (if_valid) begin
        e = (exp_pc[1:0] != 2'b00) ? 32'h0 : mem_word(exp_pc);
        checks++;
        if (if_pc !== exp_pc || if_inst !== e || if_addr_error !== (exp_pc[1:0] != 2'b00) ||
            if_inst_req !== (exp_pc[1:0] == 2'b00)) begin
          errors++;
          $display("FAIL rnd_slot@%0d: pc=%h inst=%h err=%b ireq=%b want pc=%h inst=%h",
                   c, if_pc, if_inst, if_addr_error, if_inst_req, exp_pc, e);
        end
      end
      if (hold) begin
        checks++;
        if (inst_req !== 1'b1 || inst_addr !== hold_addr) begin
          errors++;
          $display("FAIL rnd_hold@%0d: req=%b addr=%h want 1 %h", c, inst_req, inst_addr, hold_addr);
        end
      end else if (inst_req) begin
        checks++;
        if (inst_addr !== exp_pc) begin
          errors++;
          $display("FAIL rnd_addr@%0d: addr=%h want %h", c, inst_addr, exp_pc);
        end
      end
      if (inst_req) begin
        checks++;
        if (sq.size() !== 0) begin
          errors++;
          $display("FAIL rnd_outstanding@%0d: %0d in flight while requesting", c, sq.size());
        end
      end
      hold      = inst_req && !inst_addr_ok;
      hold_addr = inst_addr;
      stall     = ($urandom_range(0, 9) < 3);
      refresh   = ($urandom_range(0, 99) < 3);
      exc_pc    = 32'hBFC0_0000 | ($urandom & 32'h0000_0FFC) | (($urandom_range(0, 15) == 0) ? 32'd2 : 32'd0);
      br_taken  = ($urandom_range(0, 9) == 0);
      br_target = 32'h8000_0000 | ($urandom & 32'h0000_FFFC) | (($urandom_range(0, 7) == 0) ? 32'd1 : 32'd0);
    end
    stall = 1'b0; refresh = 1'b0; br_taken = 1'b0;
    checks++;
    if (delivered < 200) begin
      errors++;
      $display("FAIL rnd_progress: delivered %0d want at least 200", delivered);
    end
  endtask

  initial begin
    resetn = 1'b0; stall = 1'b0; refresh = 1'b0; br_taken = 1'b0;
    exc_pc = 32'h0; br_target = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_refresh_wait();
    test_refresh_req();
    test_addr_error();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- IF-stage instruction fetch initiator; produces the if_pc / if_inst_req / if_addr_error / instruction stream that the IF/ID segment register latches.
- Owns the PC register and the sram-like instruction port (req/addr_ok/data_ok).
- Buffers one returned instruction while the pipeline stalls.
- Handles exception refresh and ID-stage branch redirects, discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC value after reset.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous reset, active-low
- stall  in  1  pipeline stall; the IF/ID register holds
- refresh  in  1  exception flush; redirect to exc_pc
- exc_pc  in  32  exception/ERET target
- br_taken  in  1  ID-stage branch/jump taken (valid only when ID is not stalled)
- br_target  in  32  branch target
- inst_req  out  1  sram-like request
- inst_wr  out  1  constant 0
- inst_size  out  2  constant 2'b10
- inst_addr  out  32  request address
- inst_addr_ok  in  1  address accepted
- inst_data_ok  in  1  read data returned
- inst_rdata  in  32  read data
- if_valid  out  1  if_pc/if_inst/if_addr_error/if_inst_req valid this cycle
- if_pc  out  32  PC of the presented instruction
- if_inst  out  32  instruction word; 0 when if_addr_error
- if_addr_error  out  1  PC not word-aligned (AdEL on fetch)
- if_inst_req  out  1  1 if the presented slot came from a real bus fetch
- fetch_stall  out  1  IF cannot supply an instruction; hazard unit must stall

Behaviour:
- Reset (resetn=0 at posedge):
  - pc=RESET_PC; state=IDLE; buf_valid=0; redirect_pending=0.
  - inst_req=0, if_valid=0, if_inst=0, if_addr_error=0, if_inst_req=0, fetch_stall=1.
  - Reset aborts any transaction; responses arriving after reset are not consumed as valid; the bus is trusted to be reset alongside.
- Consume event: if_valid && !stall at a posedge. On consume, pc <= next_pc.
- next_pc priority: refresh ? exc_pc : redirect_pending ? redirect_target : br_taken ? br_target : pc+4 (mod 2^32 wrap).
- Branch redirect (delay slot semantics):
  - br_taken is sampled when the branch leaves ID.
  - The delay-slot instruction is the one currently being fetched or presented; the redirect applies to the PC after it.
  - If br_taken arrives while no consume occurs in that cycle: latch redirect_pending=1, redirect_target=br_target; clear on the next consume.
- States:
  - IDLE:
    - pc[1:0]!=0: no bus request; present if_valid=1, if_addr_error=1, if_inst=0, if_inst_req=0; wait for consume.
    - Aligned and !buf_valid: go to REQ.
  - REQ:
    - inst_req=1, inst_addr=pc; inst_req and inst_addr are held stable until inst_addr_ok, never withdrawn.
    - On addr_ok: go to WAIT, or DISCARD if a kill was flagged during REQ.
  - WAIT:
    - On data_ok: latch inst_buf=inst_rdata, buf_valid=1, go to IDLE.
    - if_valid stays 0 until buf_valid.
  - DISCARD:
    - On data_ok: drop the data, go to IDLE; the new pc is then fetched.
- Presentation: if_valid=buf_valid or the addr-error slot. When if_valid: if_pc=pc, if_inst=inst_buf, if_inst_req=1. buf_valid clears on consume.
- refresh:
  - Clears buf_valid and redirect_pending; pc<=exc_pc.
  - In WAIT: go to DISCARD.
  - In REQ: set kill flag (DISCARD after addr_ok).
  - In IDLE: stay in IDLE.
  - refresh overrides stall.
  - refresh in the same cycle as data_ok in WAIT: the data is dropped and no DISCARD is needed; go to IDLE.
- Max one outstanding request. No new request while buf_valid=1 or in DISCARD.
- fetch_stall = !if_valid. The hazard unit ORs this into the stall signal.
- Bus latency: addr_ok and data_ok may each take 0+ wait cycles. data_ok may coincide with the addr_ok cycle only if the slave supports it; treat it as arriving in WAIT the following cycle at the earliest.

Decomposition:
- Shared package (cpu_defs):
  - RESET_PC constant.
  - Fetch state enum: IDLE, REQ, WAIT, DISCARD.
  - INST_SIZE_WORD=2'b10.
- No sub-module; the single-entry instruction buffer is inline. The next-PC mux may be a function in the package.

Test Plan:
- Reset, slave with addr_ok=1 and data_ok 1 cycle later, stall=0 -> inst_addr sequence BFC00000, BFC00004, BFC00008; if_valid pulses with matching if_pc and if_inst=rdata; if_inst_req=1.
- stall=1 for 3 cycles after data_ok -> if_valid stays 1, if_pc/if_inst held, no new inst_req; after release, next request at pc+4.
- br_taken=1, br_target=80001000 while delay slot BFC00004 is in WAIT -> BFC00004 delivered; next request addr=80001000.
- refresh=1, exc_pc=BFC00380 while in WAIT -> returned data is dropped (no if_valid); next request addr=BFC00380.
- refresh during REQ with addr_ok delayed 2 cycles -> inst_req held until addr_ok; the following data_ok is discarded; then fetch BFC00380.
- br_target=80001002 -> no bus request; if_valid=1, if_addr_error=1, if_inst_req=0, if_inst=0, if_pc=80001002.
